// File: rtl/gbt_link_pkg.sv
// Shared types and defaults for the GBT link monitor: FSM state encoding
// and the default lock/loss thresholds.
package gbt_link_pkg;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2,
    LOST   = 2'd3
  } link_state_e;

  localparam int GOOD_FRAMES_DEF = 64;
  localparam int BAD_FRAMES_DEF  = 4;
  localparam int TX_CNT_WIDTH    = 16;
  localparam int FRAME_CNT_WIDTH = 8;

  // Clamp a threshold parameter into the 8-bit good/bad counter range.
  function automatic logic [FRAME_CNT_WIDTH-1:0] frame_thresh(input int n);
    if (n > 255) return 8'd255;
    if (n < 1)   return 8'd1;
    return 8'(n);
  endfunction

endpackage

// File: rtl/gbt_link_monitor_if.sv
// Status/frame bus between the GBTx receive path and the link monitor.
// frame_strobe_i is a one-cycle qualifier: header_ok_i is only meaningful
// while it is high; there is no backpressure, every strobe is consumed.
interface gbt_link_monitor_if #(
  parameter int CNT_WIDTH = 16
) ();
  import gbt_link_pkg::*;

  logic                 gbtx_rxready_raw_i;
  logic                 gbtx_txready_raw_i;
  logic                 frame_strobe_i;
  logic                 header_ok_i;
  logic                 cnt_reset_i;
  logic                 gbt_rxready_o;
  logic                 gbt_rxvalid_o;
  logic                 gbt_txready_o;
  logic [CNT_WIDTH-1:0] unlock_cnt_o;
  logic [CNT_WIDTH-1:0] bad_frame_cnt_o;
  link_state_e          state;

  modport master (
    output gbtx_rxready_raw_i,
    output gbtx_txready_raw_i,
    output frame_strobe_i,
    output header_ok_i,
    output cnt_reset_i,
    input  gbt_rxready_o,
    input  gbt_rxvalid_o,
    input  gbt_txready_o,
    input  unlock_cnt_o,
    input  bad_frame_cnt_o,
    input  state
  );

  modport slave (
    input  gbtx_rxready_raw_i,
    input  gbtx_txready_raw_i,
    input  frame_strobe_i,
    input  header_ok_i,
    input  cnt_reset_i,
    output gbt_rxready_o,
    output gbt_rxvalid_o,
    output gbt_txready_o,
    output unlock_cnt_o,
    output bad_frame_cnt_o,
    output state
  );

endinterface

// File: rtl/gbt_link_monitor_sync_ff.sv
// Multi-flop synchronizer for an asynchronous level; clears synchronously
// so a reset always presents a deasserted level downstream.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic din,
  output logic dout
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
    end
  end

  assign dout = chain[STAGES-1];

endmodule

// File: rtl/gbt_link_monitor.sv
// Qualifies GBTx RX/TX status and frame-header lock, producing stable ready
// levels for the startup reset generator plus saturating slow-control counters.
module gbt_link_monitor
  import gbt_link_pkg::*;
#(
  parameter int SYNC_STAGES      = 2,
  parameter int GOOD_FRAMES      = GOOD_FRAMES_DEF,
  parameter int BAD_FRAMES       = BAD_FRAMES_DEF,
  parameter int TX_STABLE_CYCLES = 256,
  parameter int CNT_WIDTH        = 16
) (
  input logic               clock_i,
  input logic               reset_i,
  gbt_link_monitor_if.slave bus
);

  localparam logic [FRAME_CNT_WIDTH-1:0] GOOD_TGT = frame_thresh(GOOD_FRAMES);
  localparam logic [FRAME_CNT_WIDTH-1:0] BAD_TGT  = frame_thresh(BAD_FRAMES);
  localparam logic [TX_CNT_WIDTH-1:0]    TX_TGT   = TX_CNT_WIDTH'(TX_STABLE_CYCLES);

  logic rx_s;
  logic tx_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_rx_sync (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .din     (bus.gbtx_rxready_raw_i),
    .dout    (rx_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_tx_sync (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .din     (bus.gbtx_txready_raw_i),
    .dout    (tx_s)
  );

  // TX stability filter: output register loads together with the counter
  // reaching its target, and drops as soon as tx_s is seen low.
  logic [TX_CNT_WIDTH-1:0] tx_cnt;
  logic [TX_CNT_WIDTH-1:0] tx_cnt_n;
  logic                    txready_q;
  logic                    rxready_q;

  always_comb begin
    tx_cnt_n = '0;
    if (tx_s) begin
      tx_cnt_n = (tx_cnt == TX_TGT) ? tx_cnt : tx_cnt + TX_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      tx_cnt    <= '0;
      txready_q <= 1'b0;
      rxready_q <= 1'b0;
    end else begin
      tx_cnt    <= tx_cnt_n;
      txready_q <= tx_s && (tx_cnt_n == TX_TGT);
      rxready_q <= rx_s;
    end
  end

  // Frame lock FSM
  link_state_e                state_q;
  link_state_e                state_n;
  logic [FRAME_CNT_WIDTH-1:0] good_q;
  logic [FRAME_CNT_WIDTH-1:0] good_n;
  logic [FRAME_CNT_WIDTH-1:0] bad_q;
  logic [FRAME_CNT_WIDTH-1:0] bad_n;
  logic                       unlock_inc;
  logic                       bad_inc;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= WAIT;
      good_q  <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_n;
      good_q  <= good_n;
      bad_q   <= bad_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    good_n     = good_q;
    bad_n      = bad_q;
    unlock_inc = 1'b0;
    bad_inc    = 1'b0;
    if (!rx_s) begin
      // Losing RX-ready wins over everything; an exit from lock is still counted.
      state_n    = WAIT;
      good_n     = '0;
      bad_n      = '0;
      unlock_inc = (state_q == LOCKED) || (state_q == LOST);
    end else begin
      case (state_q)
        WAIT: begin
          good_n  = '0;
          bad_n   = '0;
          state_n = HUNT;
        end
        HUNT: begin
          if (bus.frame_strobe_i) begin
            if (bus.header_ok_i) begin
              good_n = good_q + 8'd1;
              if (good_q + 8'd1 == GOOD_TGT) begin
                state_n = LOCKED;
                bad_n   = '0;
              end
            end else begin
              good_n = '0;
            end
          end
        end
        LOCKED: begin
          if (bus.frame_strobe_i) begin
            if (!bus.header_ok_i) begin
              bad_inc = 1'b1;
              bad_n   = bad_q + 8'd1;
              if (bad_q + 8'd1 == BAD_TGT) begin
                state_n = LOST;
              end
            end else begin
              bad_n = '0;
            end
          end
        end
        LOST: begin
          unlock_inc = 1'b1;
          good_n     = '0;
          state_n    = HUNT;
        end
        default: begin
          state_n = WAIT;
        end
      endcase
    end
  end

  // Slow-control counters: clear beats increment, increments saturate.
  logic [CNT_WIDTH-1:0] unlock_cnt;
  logic [CNT_WIDTH-1:0] bad_frame_cnt;

  always_ff @(posedge clock_i) begin
    if (reset_i || bus.cnt_reset_i) begin
      unlock_cnt    <= '0;
      bad_frame_cnt <= '0;
    end else begin
      if (unlock_inc && (unlock_cnt != '1)) begin
        unlock_cnt <= unlock_cnt + CNT_WIDTH'(1);
      end
      if (bad_inc && (bad_frame_cnt != '1)) begin
        bad_frame_cnt <= bad_frame_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.gbt_rxready_o   = rxready_q;
  assign bus.gbt_rxvalid_o   = (state_q == LOCKED);
  assign bus.gbt_txready_o   = txready_q;
  assign bus.unlock_cnt_o    = unlock_cnt;
  assign bus.bad_frame_cnt_o = bad_frame_cnt;
  assign bus.state           = state_q;

endmodule

// File: tb/tb_gbt_link_monitor.sv
// Bench for gbt_link_monitor: reset/sync latency, lock acquisition and loss,
// RX drop, TX filter glitch, counter saturation/clear and mid-run reset.
module tb_gbt_link_monitor;
  import gbt_link_pkg::*;

  localparam int W = 35;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  logic [W-1:0] exp_q[$];

  typedef struct packed {
    logic        ok;
    link_state_e st;
    logic        valid;
    logic [15:0] bad;
    logic [15:0] unlock;
  } vec_t;

  vec_t vtab[$];

  gbt_link_monitor_if #(.CNT_WIDTH(16)) a_if ();
  gbt_link_monitor_if #(.CNT_WIDTH(4))  b_if ();

  gbt_link_monitor #(
    .SYNC_STAGES(2), .GOOD_FRAMES(8), .BAD_FRAMES(4),
    .TX_STABLE_CYCLES(256), .CNT_WIDTH(16)
  ) dut_a (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (a_if)
  );

  gbt_link_monitor #(
    .SYNC_STAGES(2), .GOOD_FRAMES(8), .BAD_FRAMES(255),
    .TX_STABLE_CYCLES(256), .CNT_WIDTH(4)
  ) dut_b (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (b_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic ok, input link_state_e st, input logic valid,
                              input logic [15:0] bad, input logic [15:0] unlock);
    vec_t v;
    v.ok = ok; v.st = st; v.valid = valid; v.bad = bad; v.unlock = unlock;
    vtab.push_back(v);
  endfunction

  // driver tasks
  task automatic strobe_a(input logic ok);
    a_if.frame_strobe_i = 1'b1;
    a_if.header_ok_i    = ok;
    tick();
    a_if.frame_strobe_i = 1'b0;
    a_if.header_ok_i    = 1'($urandom_range(0, 1));
    tick();
    tick();
  endtask

  task automatic strobe_b(input logic ok);
    b_if.frame_strobe_i = 1'b1;
    b_if.header_ok_i    = ok;
    tick();
    b_if.frame_strobe_i = 1'b0;
    b_if.header_ok_i    = 1'($urandom_range(0, 1));
    tick();
  endtask

  task automatic apply_vec(input int i);
    logic [W-1:0] e;
    exp_q.push_back({vtab[i].st, vtab[i].valid, vtab[i].bad, vtab[i].unlock});
    strobe_a(vtab[i].ok);
    e = exp_q.pop_front();
    check($sformatf("vec%0d_state", i),  32'(a_if.state),           32'(e[34:33]));
    check($sformatf("vec%0d_valid", i),  32'(a_if.gbt_rxvalid_o),   32'(e[32]));
    check($sformatf("vec%0d_bad", i),    32'(a_if.bad_frame_cnt_o), 32'(e[31:16]));
    check($sformatf("vec%0d_unlock", i), 32'(a_if.unlock_cnt_o),    32'(e[15:0]));
  endtask

  initial begin
    logic       early;
    logic [3:0] exp_b;

    // lock acquisition: 7 good, 1 bad, 8 good
    for (int i = 0; i < 7; i++) add(1'b1, HUNT, 1'b0, 16'd0, 16'd0);
    add(1'b0, HUNT, 1'b0, 16'd0, 16'd0);
    for (int i = 0; i < 7; i++) add(1'b1, HUNT, 1'b0, 16'd0, 16'd0);
    add(1'b1, LOCKED, 1'b1, 16'd0, 16'd0);
    // hysteresis: 3 bad, 1 good, 3 bad, then 4th consecutive bad loses lock
    add(1'b0, LOCKED, 1'b1, 16'd1, 16'd0);
    add(1'b0, LOCKED, 1'b1, 16'd2, 16'd0);
    add(1'b0, LOCKED, 1'b1, 16'd3, 16'd0);
    add(1'b1, LOCKED, 1'b1, 16'd3, 16'd0);
    add(1'b0, LOCKED, 1'b1, 16'd4, 16'd0);
    add(1'b0, LOCKED, 1'b1, 16'd5, 16'd0);
    add(1'b0, LOCKED, 1'b1, 16'd6, 16'd0);
    add(1'b0, HUNT,   1'b0, 16'd7, 16'd1);
    // relock after LOST
    for (int i = 0; i < 7; i++) add(1'b1, HUNT, 1'b0, 16'd7, 16'd1);
    add(1'b1, LOCKED, 1'b1, 16'd7, 16'd1);
    // relock after RX drop
    for (int i = 0; i < 7; i++) add(1'b1, HUNT, 1'b0, 16'd7, 16'd2);
    add(1'b1, LOCKED, 1'b1, 16'd7, 16'd2);

    rst = 1'b1;
    a_if.gbtx_rxready_raw_i = 1'b1;
    a_if.gbtx_txready_raw_i = 1'b1;
    a_if.frame_strobe_i     = 1'b0;
    a_if.header_ok_i        = 1'b0;
    a_if.cnt_reset_i        = 1'b0;
    b_if.gbtx_rxready_raw_i = 1'b1;
    b_if.gbtx_txready_raw_i = 1'b0;
    b_if.frame_strobe_i     = 1'b0;
    b_if.header_ok_i        = 1'b0;
    b_if.cnt_reset_i        = 1'b0;

    // reset sequencing
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rst%0d_rxready", i), 32'(a_if.gbt_rxready_o), 32'd0);
      check($sformatf("rst%0d_txready", i), 32'(a_if.gbt_txready_o), 32'd0);
    end
    check("rst_rxvalid", 32'(a_if.gbt_rxvalid_o), 32'd0);
    check("rst_unlock",  32'(a_if.unlock_cnt_o), 32'd0);
    check("rst_bad",     32'(a_if.bad_frame_cnt_o), 32'd0);
    check("rst_state",   32'(a_if.state), 32'(WAIT));
    rst = 1'b0;
    tick();
    tick();
    check("rxready_edge2", 32'(a_if.gbt_rxready_o), 32'd0);
    tick();
    check("rxready_edge3", 32'(a_if.gbt_rxready_o), 32'd1);
    check("hunt_after_rx", 32'(a_if.state), 32'(HUNT));
    repeat (254) tick();
    check("txready_edge257", 32'(a_if.gbt_txready_o), 32'd0);
    tick();
    check("txready_edge258", 32'(a_if.gbt_txready_o), 32'd1);

    for (int i = 0; i < 32; i++) apply_vec(i);

    // RX pin drop for one cycle while LOCKED
    a_if.gbtx_rxready_raw_i = 1'b0;
    tick();
    a_if.gbtx_rxready_raw_i = 1'b1;
    tick();
    check("drop_still_locked", 32'(a_if.state), 32'(LOCKED));
    tick();
    check("drop_wait",    32'(a_if.state), 32'(WAIT));
    check("drop_valid",   32'(a_if.gbt_rxvalid_o), 32'd0);
    check("drop_rxready", 32'(a_if.gbt_rxready_o), 32'd0);
    check("drop_unlock",  32'(a_if.unlock_cnt_o), 32'd2);
    tick();
    check("drop_hunt",    32'(a_if.state), 32'(HUNT));
    check("drop_unlock1", 32'(a_if.unlock_cnt_o), 32'd2);

    for (int i = 32; i < 40; i++) apply_vec(i);

    // header_ok without strobe is ignored
    a_if.header_ok_i = 1'b0;
    repeat (5) tick();
    check("nostrobe_bad", 32'(a_if.bad_frame_cnt_o), 32'd7);

    // counter clear leaves the FSM alone
    a_if.cnt_reset_i = 1'b1;
    tick();
    a_if.cnt_reset_i = 1'b0;
    check("clr_unlock", 32'(a_if.unlock_cnt_o), 32'd0);
    check("clr_bad",    32'(a_if.bad_frame_cnt_o), 32'd0);
    check("clr_state",  32'(a_if.state), 32'(LOCKED));

    // TX filter: deassert with no hysteresis
    a_if.gbtx_txready_raw_i = 1'b0;
    tick();
    tick();
    check("txfall_edge2", 32'(a_if.gbt_txready_o), 32'd1);
    tick();
    check("txfall_edge3", 32'(a_if.gbt_txready_o), 32'd0);
    a_if.gbtx_txready_raw_i = 1'b1;
    repeat (200) tick();
    check("tx200_low", 32'(a_if.gbt_txready_o), 32'd0);
    a_if.gbtx_txready_raw_i = 1'b0;
    tick();
    a_if.gbtx_txready_raw_i = 1'b1;
    early = 1'b0;
    for (int i = 0; i < 257; i++) begin
      tick();
      if (a_if.gbt_txready_o !== 1'b0) early = 1'b1;
    end
    check("txglitch_early", 32'(early), 32'd0);
    tick();
    check("txglitch_rise", 32'(a_if.gbt_txready_o), 32'd1);

    // saturation on the 4-bit counter instance
    for (int i = 0; i < 8; i++) strobe_b(1'b1);
    check("b_locked", 32'(b_if.state), 32'(LOCKED));
    for (int n = 1; n <= 20; n++) begin
      exp_b = (n < 15) ? 4'(n) : 4'd15;
      exp_q.push_back(W'(exp_b));
      strobe_b(1'b0);
      check($sformatf("b_sat%0d", n), 32'(b_if.bad_frame_cnt_o), 32'(exp_q.pop_front()));
    end
    check("b_still_locked", 32'(b_if.state), 32'(LOCKED));
    b_if.cnt_reset_i    = 1'b1;
    b_if.frame_strobe_i = 1'b1;
    b_if.header_ok_i    = 1'b0;
    tick();
    b_if.cnt_reset_i    = 1'b0;
    b_if.frame_strobe_i = 1'b0;
    check("b_clr_vs_inc", 32'(b_if.bad_frame_cnt_o), 32'd0);
    strobe_b(1'b0);
    check("b_after_clr", 32'(b_if.bad_frame_cnt_o), 32'd1);

    // reset mid-operation with pins still high
    rst = 1'b1;
    tick();
    check("mid_state",   32'(a_if.state), 32'(WAIT));
    check("mid_rxready", 32'(a_if.gbt_rxready_o), 32'd0);
    check("mid_txready", 32'(a_if.gbt_txready_o), 32'd0);
    check("mid_rxvalid", 32'(a_if.gbt_rxvalid_o), 32'd0);
    check("mid_b_bad",   32'(b_if.bad_frame_cnt_o), 32'd0);
    check("mid_b_state", 32'(b_if.state), 32'(WAIT));
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/gbt_link_monitor.md
Name: gbt_link_monitor

Overview:
- Qualifies raw GBTx link status and per-frame header checks.
- Produces the stable gbt_rxready/gbt_rxvalid/gbt_txready levels consumed by the startup reset generator.
- Hysteresis stops a marginal link from toggling the downstream reset.
- Keeps saturating unlock and bad-frame counters for slow control.

Parameters:
SYNC_STAGES, 2, synchronizer depth for asynchronous GBTx status pins (min 2)
GOOD_FRAMES, 64, consecutive good headers required to declare lock (1..255)
BAD_FRAMES, 4, consecutive bad headers in lock required to declare loss (1..255)
TX_STABLE_CYCLES, 256, cycles synced tx-ready must stay high before gbt_txready_o asserts (1..65535)
CNT_WIDTH, 16, width of status counters

Ports:
clock_i  in  1  40 MHz frame clock
reset_i  in  1  synchronous, active-high reset
gbtx_rxready_raw_i  in  1  asynchronous GBTx RX-ready pin
gbtx_txready_raw_i  in  1  asynchronous GBTx TX-ready pin
frame_strobe_i  in  1  one-cycle pulse per received frame; header_ok_i is valid when this is high
header_ok_i  in  1  received frame header matched
cnt_reset_i  in  1  synchronous clear of both counters
gbt_rxready_o  out  1  synchronized RX-ready
gbt_rxvalid_o  out  1  frame lock established (state LOCKED)
gbt_txready_o  out  1  TX-ready, stable-filtered
unlock_cnt_o  out  CNT_WIDTH  count of LOCKED exits, saturating
bad_frame_cnt_o  out  CNT_WIDTH  count of bad headers seen while LOCKED, saturating

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- During reset, all outputs are 0, all counters are 0, synchronizer flops are 0 and the state is WAIT.
- Synchronizers:
  - Each raw pin passes through a SYNC_STAGES flop chain, giving signals rx_s and tx_s.
  - gbt_rxready_o equals rx_s, registered: pin-to-output latency is SYNC_STAGES+1 cycles.
- TX filter:
  - A 16-bit counter clears whenever tx_s=0 and increments while tx_s=1, holding at TX_STABLE_CYCLES.
  - gbt_txready_o is registered high once the counter equals TX_STABLE_CYCLES.
  - It drops the cycle after tx_s falls; there is no hysteresis on deassert.
- FSM states: WAIT, HUNT, LOCKED, LOST. good/bad counters are 8 bits each.
- WAIT:
  - good=0, bad=0.
  - Goes to HUNT when rx_s=1.
- HUNT:
  - On a strobe with header_ok=1, good increments.
  - On a strobe with header_ok=0, good is cleared to 0.
  - When a good strobe brings good to GOOD_FRAMES, go to LOCKED and clear bad.
- LOCKED:
  - On a strobe with header_ok=0, bad increments and bad_frame_cnt increments.
  - On a strobe with header_ok=1, bad is cleared.
  - When a bad strobe brings bad to BAD_FRAMES, go to LOST.
- LOST:
  - Lasts exactly one cycle; unlock_cnt increments in that cycle.
  - Then goes to HUNT with good=0.
- rx_s=0 in any state forces WAIT on the next edge. This overrides every other transition.
- If the forced WAIT is taken from LOCKED, unlock_cnt increments once.
- gbt_rxvalid_o:
  - High in the cycle following the edge that enters LOCKED.
  - Low in the cycle following the edge that leaves LOCKED.
- Strobes with no frame in flight:
  - No frame_strobe_i means no counter activity; header_ok_i is ignored.
  - A strobe arriving in WAIT or LOST is ignored.
- Counters:
  - Saturate at all-ones and never wrap.
  - cnt_reset_i has priority over a same-cycle increment: the result is 0.
  - cnt_reset_i does not affect the FSM.
- Reset mid-operation: on the next edge all state returns to its reset values, regardless of the raw pins.

Decomposition:
- Shared package gbt_link_pkg holds:
  - FSM state encoding (2-bit enum WAIT=0, HUNT=1, LOCKED=2, LOST=3);
  - default constants GOOD_FRAMES_DEF and BAD_FRAMES_DEF.
- One natural sub-module, sync_ff, a parameterized SYNC_STAGES flop chain with ASYNC_REG attributes. It is instantiated twice.

Test Plan:
- Reset sequencing: hold reset_i 5 cycles with both raw pins high, then release. Outputs stay 0 during reset. gbt_rxready_o rises 3 cycles after release (SYNC_STAGES=2). gbt_txready_o rises 256 cycles after tx_s goes high.
- Lock acquisition: GOOD_FRAMES=8, rx pin high, strobe every 3 cycles with 7 good headers, 1 bad, then 8 good. gbt_rxvalid_o rises only after the 16th strobe, one cycle after its sampling edge.
- Lock loss and hysteresis: BAD_FRAMES=4, start LOCKED. Apply 3 bad, 1 good, 3 bad: lock holds and bad_frame_cnt_o=6. Apply a 4th consecutive bad: gbt_rxvalid_o falls and unlock_cnt_o=1.
- RX pin drop: drop the rx pin for 1 cycle while LOCKED. The state enters WAIT, gbt_rxvalid_o falls and unlock_cnt_o increments by exactly 1. A full GOOD_FRAMES of good headers is required to relock.
- Counter saturation and clear: CNT_WIDTH=4 with 20 bad frames in lock (BAD_FRAMES=255). bad_frame_cnt_o holds at 15. cnt_reset_i coincident with a bad strobe gives 0.
- TX glitch: tx pin high 200 cycles, low 1 cycle, high again. gbt_txready_o stays 0 until 256 cycles after tx_s returns high.
